// File: rtl/game_retract_ctrl.sv
// game_retract_ctrl: sequencer for the undo-history bank (now / latest_1..3).
// Arbitrates init/box-move/man-move/undo requests and drives the bank's commit.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_r              synchronous active-high reset
//   i_req_init       level load/restart pulse
//   i_req_bm         box-move pulse (already validated)
//   i_req_mm         man-move pulse
//   i_req_undo       undo pulse
//   o_sel            bank source select: 0 init, 1 box, 2 man, 3 undo
//   o_game_state_en  single-cycle bank commit enable
//   o_busy           commit or settle in progress
//   o_undo_depth     valid retractable states, 0..HIST_DEPTH
//   o_steps          moves on this level, net of undos
//   o_undo_err       one-cycle pulse on a rejected undo
//   o_undo_left      remaining undo budget (GAME_RETRACT_LIMIT_EN only)
//
// Optional feature macro: GAME_RETRACT_LIMIT_EN adds a per-level undo budget.
module game_retract_ctrl #(
    parameter int HIST_DEPTH    = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int STEP_W        = 10
`ifdef GAME_RETRACT_LIMIT_EN
    ,
    parameter int UNDO_BUDGET   = 3
`endif
) (
    input  logic              i_clk,
    input  logic              i_r,
    input  logic              i_req_init,
    input  logic              i_req_bm,
    input  logic              i_req_mm,
    input  logic              i_req_undo,
    output logic [1:0]        o_sel,
    output logic              o_game_state_en,
    output logic              o_busy,
    output logic [1:0]        o_undo_depth,
    output logic [STEP_W-1:0] o_steps,
    output logic              o_undo_err
`ifdef GAME_RETRACT_LIMIT_EN
    ,
    output logic [1:0]        o_undo_left
`endif
);

    localparam logic [1:0] SEL_INIT = 2'd0;
    localparam logic [1:0] SEL_BM   = 2'd1;
    localparam logic [1:0] SEL_MM   = 2'd2;
    localparam logic [1:0] SEL_UNDO = 2'd3;

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_ISSUE,
        S_SETTLE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_pend_v;
    logic [1:0]          r_pend_sel;
    logic [1:0]          r_sel;
    logic                r_en;
    logic                r_busy;
    logic                r_err;
    logic [1:0]          r_undo_depth;
    logic [STEP_W-1:0]   r_steps;

    logic                w_req_any;
    logic [1:0]          w_req_sel;
    logic                w_cand_v;
    logic [1:0]          w_cand_sel;
    logic                w_arb;
    logic                w_undo_ok;
    logic                w_reject;
    logic                w_go;
    logic [1:0]          w_sel_nxt;
    logic                w_en_nxt;
    logic                w_busy_nxt;
    logic                w_err_nxt;

`ifdef GAME_RETRACT_LIMIT_EN
    logic [1:0]          r_budget;
`endif

    // Priority rank: init > undo > bm > mm.
    function automatic logic [1:0] f_rank(input logic [1:0] s);
        case (s)
            SEL_INIT: return 2'd3;
            SEL_UNDO: return 2'd2;
            SEL_BM:   return 2'd1;
            default:  return 2'd0;
        endcase
    endfunction

    assign w_req_any = i_req_init | i_req_bm | i_req_mm | i_req_undo;

    always_comb begin
        w_req_sel = SEL_MM;
        if (i_req_init)      w_req_sel = SEL_INIT;
        else if (i_req_undo) w_req_sel = SEL_UNDO;
        else if (i_req_bm)   w_req_sel = SEL_BM;
    end

    // Merge live requests with the pending slot; higher rank wins.
    always_comb begin
        w_cand_v   = w_req_any | r_pend_v;
        w_cand_sel = w_req_sel;
        if (r_pend_v &&
            (!w_req_any || (f_rank(r_pend_sel) > f_rank(w_req_sel))))
            w_cand_sel = r_pend_sel;
    end

    // Arbitration happens in IDLE and on the last SETTLE cycle, so a
    // pending request goes straight to ISSUE when settling ends.
    assign w_arb = (r_state == S_IDLE) ||
                   ((r_state == S_SETTLE) && (r_cnt == 4'd0));

`ifdef GAME_RETRACT_LIMIT_EN
    assign w_undo_ok = (r_undo_depth != 2'd0) && (r_budget != 2'd0);
`else
    assign w_undo_ok = (r_undo_depth != 2'd0);
`endif

    assign w_reject = w_arb && w_cand_v &&
                      (w_cand_sel == SEL_UNDO) && !w_undo_ok;
    assign w_go     = w_arb && w_cand_v && !w_reject;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_r) r_state <= S_BOOT;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:   w_state_nxt = S_ISSUE;
            S_IDLE:   w_state_nxt = w_go ? S_ISSUE : S_IDLE;
            S_ISSUE:  w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = w_go ? S_ISSUE : S_IDLE;
            end
            default:  w_state_nxt = S_BOOT;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        w_sel_nxt = r_sel;
        if (r_state == S_BOOT) w_sel_nxt = SEL_INIT;
        else if (w_go)         w_sel_nxt = w_cand_sel;
        w_en_nxt   = (w_state_nxt == S_ISSUE);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_err_nxt  = w_reject;
    end

    always_ff @(posedge i_clk) begin
        if (i_r) begin
            r_sel  <= SEL_INIT;
            r_en   <= 1'b0;
            r_busy <= 1'b1;
            r_err  <= 1'b0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_en   <= w_en_nxt;
            r_busy <= w_busy_nxt;
            r_err  <= w_err_nxt;
        end
    end

    // Pending slot: filled while busy, consumed at arbitration.
    always_ff @(posedge i_clk) begin
        if (i_r) begin
            r_pend_v   <= 1'b0;
            r_pend_sel <= SEL_INIT;
        end else if (w_arb) begin
            r_pend_v   <= 1'b0;
        end else if (w_req_any &&
                     (!r_pend_v || (f_rank(w_req_sel) > f_rank(r_pend_sel)))) begin
            r_pend_v   <= 1'b1;
            r_pend_sel <= w_req_sel;
        end
    end

    // Settle down-counter, loaded as ISSUE ends.
    always_ff @(posedge i_clk) begin
        if (i_r)
            r_cnt <= 4'd0;
        else if (r_state == S_ISSUE)
            r_cnt <= 4'(SETTLE_CYCLES - 1);
        else if ((r_state == S_SETTLE) && (r_cnt != 4'd0))
            r_cnt <= r_cnt - 4'd1;
    end

    // Bookkeeping, written during the ISSUE cycle.
    always_ff @(posedge i_clk) begin
        if (i_r) begin
            r_undo_depth <= 2'd0;
            r_steps      <= '0;
        end else if (r_state == S_ISSUE) begin
            case (r_sel)
                SEL_INIT: begin
                    r_undo_depth <= 2'd0;
                    r_steps      <= '0;
                end
                SEL_UNDO: begin
                    if (r_undo_depth != 2'd0)
                        r_undo_depth <= r_undo_depth - 2'd1;
                    if (r_steps != '0)
                        r_steps <= r_steps - {{(STEP_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    if (r_undo_depth < 2'(HIST_DEPTH))
                        r_undo_depth <= r_undo_depth + 2'd1;
                    r_steps <= r_steps + {{(STEP_W-1){1'b0}}, 1'b1};
                end
            endcase
        end
    end

`ifdef GAME_RETRACT_LIMIT_EN
    always_ff @(posedge i_clk) begin
        if (i_r)
            r_budget <= 2'(UNDO_BUDGET);
        else if (r_state == S_ISSUE) begin
            if (r_sel == SEL_INIT)
                r_budget <= 2'(UNDO_BUDGET);
            else if ((r_sel == SEL_UNDO) && (r_budget != 2'd0))
                r_budget <= r_budget - 2'd1;
        end
    end

    assign o_undo_left = r_budget;
`endif

    assign o_sel           = r_sel;
    assign o_game_state_en = r_en;
    assign o_busy          = r_busy;
    assign o_undo_depth    = r_undo_depth;
    assign o_steps         = r_steps;
    assign o_undo_err      = r_err;

endmodule

// File: tb/tb_game_retract_ctrl.sv
// tb_game_retract_ctrl: directed and randomized checks of game_retract_ctrl
// against a transaction-level model of depth, steps, budget and commits.
module tb_game_retract_ctrl;

    localparam int STEP_W = 10;
    localparam int HIST   = 3;
    localparam int SETTLE = 2;
`ifdef GAME_RETRACT_LIMIT_EN
    localparam int BUDGET = 1;
`endif

    logic              clk = 1'b0;
    logic              r   = 1'b1;
    logic              ri  = 1'b0;
    logic              rb  = 1'b0;
    logic              rm  = 1'b0;
    logic              ru  = 1'b0;
    logic [1:0]        sel;
    logic              en;
    logic              busy;
    logic [1:0]        depth;
    logic [STEP_W-1:0] steps;
    logic              err;
`ifdef GAME_RETRACT_LIMIT_EN
    logic [1:0]        left;
`endif

    always #5 clk = ~clk;

    game_retract_ctrl #(
        .HIST_DEPTH    (HIST),
        .SETTLE_CYCLES (SETTLE),
        .STEP_W        (STEP_W)
`ifdef GAME_RETRACT_LIMIT_EN
        ,
        .UNDO_BUDGET   (BUDGET)
`endif
    ) dut (
        .i_clk           (clk),
        .i_r             (r),
        .i_req_init      (ri),
        .i_req_bm        (rb),
        .i_req_mm        (rm),
        .i_req_undo      (ru),
        .o_sel           (sel),
        .o_game_state_en (en),
        .o_busy          (busy),
        .o_undo_depth    (depth),
        .o_steps         (steps),
        .o_undo_err      (err)
`ifdef GAME_RETRACT_LIMIT_EN
        ,
        .o_undo_left     (left)
`endif
    );

    int checks = 0;
    int errors = 0;
    int n_en   = 0;
    int n_sel3 = 0;
    int n_err  = 0;
    logic [1:0] last_sel = 2'd0;

    // Event monitor on the opposite edge.
    always @(negedge clk) begin
        if (en) begin
            n_en++;
            last_sel = sel;
            if (sel == 2'd3) n_sel3++;
        end
        if (err) n_err++;
    end

    // Reference model (transaction level).
    int m_depth  = 0;
    int m_steps  = 0;
    int m_budget = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] m);
        {ri, ru, rb, rm} = m;
    endtask

    task automatic drive(input logic [3:0] m);
        set_req(m);
        step();
        set_req(4'b0000);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Mask order {init, undo, bm, mm}; code 0 init, 1 bm, 2 mm, 3 undo.
    function automatic logic [1:0] winner(input logic [3:0] m);
        if (m[3]) return 2'd0;
        if (m[2]) return 2'd3;
        if (m[1]) return 2'd1;
        return 2'd2;
    endfunction

    function automatic bit rejected(input logic [1:0] s);
        if (s != 2'd3) return 1'b0;
`ifdef GAME_RETRACT_LIMIT_EN
        return (m_depth == 0) || (m_budget == 0);
`else
        return (m_depth == 0);
`endif
    endfunction

    task automatic model_reset();
        m_depth  = 0;
        m_steps  = 0;
`ifdef GAME_RETRACT_LIMIT_EN
        m_budget = BUDGET;
`endif
    endtask

    task automatic apply(input logic [1:0] s);
        case (s)
            2'd0: model_reset();
            2'd3: begin
                m_depth  = m_depth - 1;
                m_steps  = (m_steps > 0) ? m_steps - 1 : 0;
                m_budget = m_budget - 1;
            end
            default: begin
                m_depth = (m_depth + 1 > HIST) ? HIST : m_depth + 1;
                m_steps = (m_steps + 1) % (1 << STEP_W);
            end
        endcase
    endtask

    task automatic chk_book(input string tag);
        chk({tag, "_depth"}, 32'(depth), 32'(m_depth));
        chk({tag, "_steps"}, 32'(steps), 32'(m_steps));
`ifdef GAME_RETRACT_LIMIT_EN
        chk({tag, "_left"}, 32'(left), 32'(m_budget));
`endif
    endtask

    // Issue one request from IDLE and follow it to IDLE again.
    task automatic txn(input string tag, input logic [3:0] m);
        logic [1:0] w;
        int n;
        w = winner(m);
        if (rejected(w)) begin
            drive(m);
            chk({tag, "_err"}, 32'(err), 32'd1);
            chk({tag, "_en"}, 32'(en), 32'd0);
            step();
            chk({tag, "_err_clr"}, 32'(err), 32'd0);
        end else begin
            drive(m);
            chk({tag, "_en"}, 32'(en), 32'd1);
            chk({tag, "_sel"}, 32'(sel), 32'(w));
            apply(w);
            wait_idle(n);
        end
        chk_book(tag);
    endtask

    initial begin
        int n;
        int e0;
        int r0;
        int s0;
        int exp_en;
        int exp_err;
        logic [3:0] m1;
        logic [3:0] m2;
        logic [1:0] w1;
        logic [1:0] w2;
        bit inj;

        // Reset and boot init
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        model_reset();
        chk_book("rst");
        r = 1'b0;
        step();
        chk("boot_en", 32'(en), 32'd1);
        chk("boot_sel", 32'(sel), 32'd0);
        step();
        chk("boot_en_1cyc", 32'(en), 32'd0);
        wait_idle(n);
        chk("boot_settle_len", 32'(n), 32'(SETTLE));
        chk_book("boot");

        // Four man moves, depth saturates
        for (int i = 0; i < 4; i++) txn("mm", 4'b0001);

        // Four undos, last one rejected
        for (int i = 0; i < 4; i++) txn("undo", 4'b0100);
        chk("undo_steps_final", 32'(steps), 32'd1);

        // mm then bm while busy -> only bm issued after settle
        e0 = n_en;
        drive(4'b0001);
        chk("pend_first_sel", 32'(sel), 32'd2);
        apply(2'd2);
        drive(4'b0001);
        drive(4'b0010);
        chk("pend_gap_en", 32'(en), 32'd0);
        step();
        chk("pend_issue_en", 32'(en), 32'd1);
        chk("pend_issue_sel", 32'(sel), 32'd1);
        apply(2'd1);
        wait_idle(n);
        chk("pend_en_count", 32'(n_en - e0), 32'd2);
        chk_book("pend");

        // init + undo together with depth 2
        r0 = n_err;
        txn("init_undo", 4'b1100);
        chk("init_undo_noerr", 32'(n_err - r0), 32'd0);

        // Reset during SETTLE with a pending undo
        s0 = n_sel3;
        e0 = n_en;
        drive(4'b0001);
        drive(4'b0100);
        r = 1'b1;
        step();
        chk("abort_en", 32'(en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        step();
        r = 1'b0;
        model_reset();
        step();
        chk("reboot_en", 32'(en), 32'd1);
        chk("reboot_sel", 32'(sel), 32'd0);
        wait_idle(n);
        repeat (5) step();
        chk("abort_no_undo", 32'(n_sel3 - s0), 32'd0);
        chk("abort_en_count", 32'(n_en - e0), 32'd2);
        chk_book("abort");

`ifdef GAME_RETRACT_LIMIT_EN
        // Budget of one undo per level
        txn("lim_init", 4'b1000);
        txn("lim_mm0", 4'b0001);
        txn("lim_mm1", 4'b0001);
        txn("lim_undo0", 4'b0100);
        txn("lim_undo1", 4'b0100);
        chk("lim_depth", 32'(depth), 32'd1);
        chk("lim_left", 32'(left), 32'd0);
`endif

        // Randomized: a request from IDLE, optionally a second while busy
        for (int it = 0; it < 60; it++) begin
            m1  = 4'($urandom_range(1, 15));
            m2  = 4'($urandom_range(1, 15));
            inj = 1'($urandom_range(0, 1));
            e0  = n_en;
            r0  = n_err;
            exp_en  = 0;
            exp_err = 0;
            w1 = winner(m1);
            if (rejected(w1)) begin
                drive(m1);
                exp_err++;
                chk("rnd_rej_en", 32'(en), 32'd0);
            end else begin
                drive(m1);
                chk("rnd_sel", 32'(sel), 32'(w1));
                apply(w1);
                exp_en++;
                if (inj) begin
                    drive(m2);
                    w2 = winner(m2);
                    if (rejected(w2)) exp_err++;
                    else begin
                        apply(w2);
                        exp_en++;
                    end
                end
                wait_idle(n);
            end
            step();
            step();
            chk("rnd_en_count", 32'(n_en - e0), 32'(exp_en));
            chk("rnd_err_count", 32'(n_err - r0), 32'(exp_err));
            chk_book("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
